// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receiver: FSM state encoding and
// oversampling geometry (16 ticks per bit, start bit checked at its middle).
package spart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } spart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int DATA_BITS  = 8;

  localparam logic [3:0] LAST_TICK    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK_CNT = 4'(MID_TICK);

endpackage

// File: rtl/spart_sync.sv
// Multi-flop synchronizer for the asynchronous RxD line; resets to the idle
// (high) level so a reset never looks like a start bit.
module spart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 deserializer with data-available,
// framing-error and overrun flags. o_state exposes the FSM for observation.
module spart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxEnable,
  input  logic                 RxD,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [1:0]           o_state
);

  import spart_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  spart_state_e         r_state;
  spart_state_e         w_state_nxt;
  logic                 w_rx_s;
  logic [3:0]           r_tick_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rda;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_mid_tick;
  logic                 w_last_tick;
  logic                 w_cnt_clr;
  logic                 w_shift_en;
  logic                 w_done;

  spart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (RxD),
    .o_q (w_rx_s)
  );

  assign w_mid_tick  = rxEnable && (r_tick_cnt == MID_TICK_CNT);
  assign w_last_tick = rxEnable && (r_tick_cnt == LAST_TICK);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (rxEnable && !w_rx_s) w_state_nxt = ST_START;
      ST_START: if (w_mid_tick) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_last_tick && (r_bit_cnt == LAST_BIT)) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_last_tick) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE:  w_cnt_clr = 1'b1;
      ST_START: w_cnt_clr = w_mid_tick;
      ST_DATA: begin
        w_shift_en = w_last_tick;
        w_cnt_clr  = w_last_tick;
      end
      ST_STOP: begin
        w_done    = w_last_tick;
        w_cnt_clr = w_last_tick;
      end
      default:  w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      if (rxEnable) r_tick_cnt <= w_cnt_clr ? 4'd0 : r_tick_cnt + 4'd1;
      if (r_state != ST_DATA) r_bit_cnt <= '0;
      else if (w_shift_en)    r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

  // rda/clr_rda: rda rises one clk after the stop sample; a one-clk clr_rda
  // drops rda and both error flags, but a completion in that same clk wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data   <= '0;
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_done) begin
      r_rx_data   <= r_shift;
      r_rda       <= 1'b1;
      r_frame_err <= ~w_rx_s;
      r_overrun   <= r_rda & ~clr_rda;
    end else if (clr_rda) begin
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign rx_data   = r_rx_data;
  assign rda       = r_rda;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign o_state   = r_state;

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: frames driven at 64 clks/bit with rxEnable every 4 clks;
// expected {overrun, frame_err, data} words are queued and checked on completion.
module tb_spart_rx;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxEnable;
  logic       RxD = 1'b1;
  logic       clr_rda = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       frame_err;
  logic       overrun;
  logic [1:0] o_state;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp;
  logic [1:0] ph = 2'd0;

  spart_rx #(.SYNC_STAGES(2), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxEnable  (rxEnable),
    .RxD       (RxD),
    .clr_rda   (clr_rda),
    .rx_data   (rx_data),
    .rda       (rda),
    .frame_err (frame_err),
    .overrun   (overrun),
    .o_state   (o_state)
  );

  // clock / tick generation
  always #5 clk = ~clk;

  initial begin
    rxEnable = 1'b0;
    forever begin
      @(negedge clk);
      ph = ph + 2'd1;
      rxEnable = (ph == 2'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_bit(input logic b);
    RxD = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    RxD = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rda = 1'b1;
    @(negedge clk);
    clr_rda = 1'b0;
    @(negedge clk);
  endtask

  // Returns just before the posedge carrying the 16th tick after STOP entry.
  task automatic wait_done_edge(output bit ok);
    int ticks;
    int guard;
    ok = 1'b0;
    guard = 0;
    while (o_state !== ST_STOP && guard < 2000) begin
      @(negedge clk); #1; guard++;
    end
    if (o_state !== ST_STOP) return;
    ticks = 0;
    while (guard < 2000) begin
      if (rxEnable) begin
        ticks++;
        if (ticks == 16) begin
          ok = 1'b1;
          return;
        end
      end
      @(negedge clk); #1; guard++;
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      RxD = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    RxD = 1'b1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL reset_rda got=%b exp=0", rda); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_tests++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", o_state, ST_IDLE); end
  endtask

  task automatic test_basic();
    bit ok;
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_done_edge(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_stop_tick got=not_reached exp=reached"); end
        if (ok) begin
          n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL basic_rda_early got=%b exp=0", rda); end
          @(negedge clk);
          n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL basic_rda_latency got=%b exp=1", rda); end
        end
      end
    join
    exp = exp_q.pop_front();
    n_tests++; if (rx_data !== exp[7:0]) begin n_fail++; $display("FAIL basic_data got=%h exp=%h", rx_data, exp[7:0]); end
    n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL basic_rda got=%b exp=1", rda); end
    n_tests++; if (frame_err !== exp[8]) begin n_fail++; $display("FAIL basic_frame_err got=%b exp=%b", frame_err, exp[8]); end
    n_tests++; if (overrun !== exp[9]) begin n_fail++; $display("FAIL basic_overrun got=%b exp=%b", overrun, exp[9]); end
    pulse_clr();
    n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL basic_clr_rda got=%b exp=0", rda); end
  endtask

  task automatic test_glitch();
    RxD = 1'b0;
    repeat (12) @(negedge clk);
    n_tests++; if (o_state !== ST_START) begin n_fail++; $display("FAIL glitch_in_start got=%0d exp=%0d", o_state, ST_START); end
    RxD = 1'b1;
    repeat (64) @(negedge clk);
    n_tests++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL glitch_state got=%0d exp=%0d", o_state, ST_IDLE); end
    n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL glitch_rda got=%b exp=0", rda); end
  endtask

  task automatic test_frame_err();
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    send_frame(8'h3C, 1'b0);
    repeat (64) @(negedge clk);
    exp = exp_q.pop_front();
    n_tests++; if (rx_data !== exp[7:0]) begin n_fail++; $display("FAIL ferr_data got=%h exp=%h", rx_data, exp[7:0]); end
    n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL ferr_rda got=%b exp=1", rda); end
    n_tests++; if (frame_err !== exp[8]) begin n_fail++; $display("FAIL ferr_flag got=%b exp=%b", frame_err, exp[8]); end
    n_tests++; if (overrun !== exp[9]) begin n_fail++; $display("FAIL ferr_overrun got=%b exp=%b", overrun, exp[9]); end
    pulse_clr();
    n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL ferr_clr_rda got=%b exp=0", rda); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clr_flag got=%b exp=0", frame_err); end
    n_tests++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_clr_hold got=%h exp=3c", rx_data); end
    pulse_clr();
    n_tests++; if (rda !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL clr_idle_flags got=%b%b%b exp=000", rda, frame_err, overrun);
    end
    n_tests++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL clr_idle_hold got=%h exp=3c", rx_data); end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    exp_q.push_back({1'b1, 1'b0, 8'h22});
    send_frame(8'h11, 1'b1);
    exp = exp_q.pop_front();
    n_tests++; if (rx_data !== exp[7:0]) begin n_fail++; $display("FAIL b2b_first_data got=%h exp=%h", rx_data, exp[7:0]); end
    n_tests++; if (overrun !== exp[9]) begin n_fail++; $display("FAIL b2b_first_overrun got=%b exp=%b", overrun, exp[9]); end
    send_frame(8'h22, 1'b1);
    exp = exp_q.pop_front();
    n_tests++; if (rx_data !== exp[7:0]) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", rx_data, exp[7:0]); end
    n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL b2b_rda got=%b exp=1", rda); end
    n_tests++; if (overrun !== exp[9]) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=%b", overrun, exp[9]); end
    n_tests++; if (frame_err !== exp[8]) begin n_fail++; $display("FAIL b2b_frame_err got=%b exp=%b", frame_err, exp[8]); end
    pulse_clr();
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_clr_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    RxD = d[4];
    repeat (32) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    RxD = 1'b1;
    repeat (16) @(negedge clk);
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data); end
    n_tests++; if (rda !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags got=%b%b%b exp=000", rda, frame_err, overrun);
    end
    n_tests++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state got=%0d exp=%0d", o_state, ST_IDLE); end
    exp_q.push_back({1'b0, 1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1);
    exp = exp_q.pop_front();
    n_tests++; if (rx_data !== exp[7:0]) begin n_fail++; $display("FAIL midrst_next_data got=%h exp=%h", rx_data, exp[7:0]); end
    n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL midrst_next_rda got=%b exp=1", rda); end
    n_tests++; if ({overrun, frame_err} !== exp[9:8]) begin n_fail++; $display("FAIL midrst_next_flags got=%b%b exp=%b", overrun, frame_err, exp[9:8]); end
    pulse_clr();
  endtask

  task automatic test_clr_collision();
    bit ok;
    exp_q.push_back({1'b0, 1'b0, 8'h66});
    send_frame(8'h66, 1'b1);
    exp = exp_q.pop_front();
    n_tests++; if (rx_data !== exp[7:0] || rda !== 1'b1) begin n_fail++; $display("FAIL coll_first got=%h/%b exp=%h/1", rx_data, rda, exp[7:0]); end
    exp_q.push_back({1'b0, 1'b0, 8'h77});
    fork
      send_frame(8'h77, 1'b1);
      begin
        wait_done_edge(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL coll_stop_tick got=not_reached exp=reached"); end
        if (ok) begin
          clr_rda = 1'b1;
          @(negedge clk);
          clr_rda = 1'b0;
        end
      end
    join
    exp = exp_q.pop_front();
    n_tests++; if (rx_data !== exp[7:0]) begin n_fail++; $display("FAIL coll_data got=%h exp=%h", rx_data, exp[7:0]); end
    n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL coll_rda got=%b exp=1", rda); end
    n_tests++; if (overrun !== exp[9]) begin n_fail++; $display("FAIL coll_overrun got=%b exp=%b", overrun, exp[9]); end
    n_tests++; if (frame_err !== exp[8]) begin n_fail++; $display("FAIL coll_frame_err got=%b exp=%b", frame_err, exp[8]); end
  endtask

  initial begin
    test_reset();
    repeat ($urandom_range(8, 40)) @(negedge clk);
    test_basic();
    repeat ($urandom_range(8, 40)) @(negedge clk);
    test_glitch();
    repeat ($urandom_range(8, 40)) @(negedge clk);
    test_frame_err();
    repeat ($urandom_range(8, 40)) @(negedge clk);
    test_back_to_back();
    repeat ($urandom_range(8, 40)) @(negedge clk);
    test_reset_midframe();
    repeat ($urandom_range(8, 40)) @(negedge clk);
    test_clr_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
